// File: rtl/fir_pkg.sv
// Shared FIR constants and the output stage defaults.
// FIR_SUM_W and FIR_SAMPLE_W are also used by the FIR block.
package fir_pkg;

    localparam int FIR_SUM_W    = 17;
    localparam int FIR_SAMPLE_W = 8;
    localparam int DEF_SHIFT    = 4;
    localparam int DEF_DEPTH    = 8;

    // FIFO operation this cycle, encoded as {push, pop}
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/fir_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module fir_sync_fifo
    import fir_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          drop
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;
    fifo_op_e      op;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & ~do_push;
    assign op      = fifo_op_e'({do_push, do_pop});

    // Memory is not reset, so mask the head while empty
    assign dout = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            unique case (op)
                OP_PUSH: count <= count + (AW+1)'(1);
                OP_POP:  count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fir_out_decim_fifo.sv
// FIR output stage: round, scale, saturate, decimate, then buffer
// surviving samples in a FIFO behind a valid/ready handshake.
module fir_out_decim_fifo
    import fir_pkg::*;
#(
    parameter int IN_W  = FIR_SUM_W,
    parameter int OUT_W = FIR_SAMPLE_W,
    parameter int SHIFT = DEF_SHIFT,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [IN_W-1:0]          in_data,
    input  logic [3:0]               decim,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clr_ovf
);

    localparam logic [IN_W:0] HALF = (IN_W+1)'(1) << (SHIFT-1);
    localparam logic [IN_W:0] MAXV = (IN_W+1)'((1 << OUT_W) - 1);

    logic [IN_W:0]  rnd;
    logic [IN_W:0]  shr;
    logic [OUT_W-1:0] scaled;
    logic [3:0]     phase;
    logic           keep;
    logic           st_valid;
    logic [OUT_W-1:0] st_data;
    logic           empty;
    logic           drop;
    logic           pop;

    // One extra bit keeps the rounding carry
    assign rnd    = {1'b0, in_data} + HALF;
    assign shr    = rnd >> SHIFT;
    assign scaled = (shr > MAXV) ? '1 : shr[OUT_W-1:0];

    assign keep = in_valid & (phase == 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= 4'd0;
        end else if (in_valid) begin
            phase <= (phase >= decim) ? 4'd0 : phase + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_valid <= 1'b0;
            st_data  <= '0;
        end else begin
            st_valid <= keep;
            if (keep)
                st_data <= scaled;
        end
    end

    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;

    fir_sync_fifo #(
        .W     (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (st_valid),
        .din   (st_data),
        .pop   (pop),
        .dout  (out_data),
        .empty (empty),
        .count (count),
        .drop  (drop)
    );

    // Setting wins over a same-cycle clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            overflow <= 1'b0;
        else if (drop)
            overflow <= 1'b1;
        else if (clr_ovf)
            overflow <= 1'b0;
    end

endmodule
